load_store_unit: RTL and testbench

Data-memory access controller between the execute stage and the data bus. It accepts one load or store per request, checks alignment, and runs a single-beat Wishbone-style classic bus cycle with a watchdog timeout. For loads it returns read data shifted to bit 0; this feeds `load_generator.I_data`, which performs the sign or zero extension. The block stalls the pipeline until the access completes.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit_store_aligner.sv | 32 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM state
// encodings and the alignment rule used when a request is accepted.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    // Size code 11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and data-bus signals of the load/store unit.
// The unit is the bus master; the slave modport is the view of everything
// around it (pipeline and bus slave).
interface load_store_unit_if;
    logic        I_req;
    logic        I_we;
    logic [1:0]  I_size;
    logic [31:0] I_addr;
    logic [31:0] I_wdata;
    logic [31:0] O_rdata;
    logic        O_done;
    logic        O_stall;
    logic        O_misaligned;
    logic        O_bus_err;
    logic        O_bus_cyc;
    logic        O_bus_stb;
    logic        O_bus_we;
    logic [31:0] O_bus_adr;
    logic [3:0]  O_bus_sel;
    logic [31:0] O_bus_dat;
    logic [31:0] I_bus_dat;
    logic        I_bus_ack;
    logic        I_bus_err;

    modport master (
        input  I_req, I_we, I_size, I_addr, I_wdata, I_bus_dat, I_bus_ack, I_bus_err,
        output O_rdata, O_done, O_stall, O_misaligned, O_bus_err,
               O_bus_cyc, O_bus_stb, O_bus_we, O_bus_adr, O_bus_sel, O_bus_dat
    );

    modport slave (
        output I_req, I_we, I_size, I_addr, I_wdata, I_bus_dat, I_bus_ack, I_bus_err,
        input  O_rdata, O_done, O_stall, O_misaligned, O_bus_err,
               O_bus_cyc, O_bus_stb, O_bus_we, O_bus_adr, O_bus_sel, O_bus_dat
    );
endinterface

// File: rtl/load_store_unit_store_aligner.sv
// Byte-lane steering for stores: derives the lane enables from size and
// address offset and replicates the right-justified store data onto every
// lane it could land on. Loads reuse the sel output.
module store_aligner
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] dat
);

    // Lane enables and replicated data per access size.
    always_comb begin
        case (size)
            SIZE_B: begin
                sel = 4'b0001 << off;
                dat = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                sel = 4'b0011 << off;
                dat = {2{wdata[15:0]}};
            end
            default: begin
                sel = 4'b1111;
                dat = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access controller: one load or store per request, alignment
// check, a single-beat classic bus cycle with a watchdog, and right-justified
// load data for the downstream extension stage.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    load_store_unit_if.master   bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  off_q, off_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;

    logic [3:0]  al_sel;
    logic [31:0] al_dat;

    store_aligner u_store_aligner (
        .size  (bus.I_size),
        .off   (bus.I_addr[1:0]),
        .wdata (bus.I_wdata),
        .sel   (al_sel),
        .dat   (al_dat)
    );

    // Next-state and bus-register update for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        mis_d   = mis_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.I_req) begin
                    if (is_misaligned(bus.I_size, bus.I_addr[1:0])) begin
                        // No bus cycle for a fault; report it straight away.
                        mis_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cyc_d   = 1'b1;
                        we_d    = bus.I_we;
                        adr_d   = {bus.I_addr[31:2], 2'b00};
                        sel_d   = al_sel;
                        dat_d   = al_dat;
                        off_d   = bus.I_addr[1:0];
                        cnt_d   = 8'd0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.I_bus_err) begin
                    // Error takes priority over a simultaneous ack.
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (bus.I_bus_ack) begin
                    cyc_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.I_bus_dat >> {off_q, 3'b000};
                    end
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                mis_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including read data.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            off_q   <= 2'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_rdata      = rdata_q;
    assign bus.O_done       = done_q;
    assign bus.O_misaligned = mis_q;
    assign bus.O_bus_err    = err_q;
    assign bus.O_bus_cyc    = cyc_q;
    assign bus.O_bus_stb    = cyc_q;
    assign bus.O_bus_we     = we_q;
    assign bus.O_bus_adr    = adr_q;
    assign bus.O_bus_sel    = sel_q;
    assign bus.O_bus_dat    = dat_q;
    assign bus.O_stall      = bus.I_req & ~done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: each access pushes its expected
// response when driven; the response is popped and compared at O_done.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          done_cyc;
        int          stb_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] model_rdata = 32'd0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // mode: 0 ack, 1 err, 2 ack+err together, 3 no response (watchdog)
    task automatic run_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits, input int mode,
                              input logic [31:0] bdat);
        exp_t        e;
        exp_t        r;
        logic [1:0]  off;
        int          cyc;
        int          stb_n;
        logic        done;
        off   = addr[1:0];
        e.mis = (size == SIZE_H) ? off[0] : (size == SIZE_B) ? 1'b0 : (off != 2'b00);
        e.err = !e.mis && (mode != 0);
        for (int i = 0; i < 4; i++) begin
            if (size == SIZE_B)      e.sel[i] = (i == int'(off));
            else if (size == SIZE_H) e.sel[i] = (i == int'(off)) || (i == int'(off) + 1);
            else                     e.sel[i] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (size == SIZE_B)      e.dat[8*i +: 8] = wdata[7:0];
            else if (size == SIZE_H) e.dat[8*i +: 8] = (i % 2 == 0) ? wdata[7:0] : wdata[15:8];
            else                     e.dat[8*i +: 8] = wdata[8*i +: 8];
        end
        e.adr = addr & 32'hFFFF_FFFC;
        e.we  = we;
        if (!e.mis && mode == 0 && !we) model_rdata = bdat >> (8 * int'(off));
        e.rdata    = model_rdata;
        e.done_cyc = e.mis ? 1 : (mode == 3) ? 5 : waits + 2;
        e.stb_cnt  = e.mis ? 0 : (mode == 3) ? 4 : waits + 1;
        sb_q.push_back(e);

        @(negedge clk);
        bus.I_req = 1'b1; bus.I_we = we; bus.I_size = size;
        bus.I_addr = addr; bus.I_wdata = wdata;
        #1 check_vec("stall_req", {31'd0, bus.O_stall}, 32'd1);
        cyc = 0; stb_n = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.I_bus_ack = 1'b0; bus.I_bus_err = 1'b0; bus.I_bus_dat = 32'hDEAD_DEAD;
            if (bus.O_bus_stb) begin
                stb_n++;
                if (stb_n == 1) begin
                    check_vec("bus_adr", bus.O_bus_adr, sb_q[0].adr);
                    check_vec("bus_sel", {28'd0, bus.O_bus_sel}, {28'd0, sb_q[0].sel});
                    check_vec("bus_we", {31'd0, bus.O_bus_we}, {31'd0, sb_q[0].we});
                    if (we) check_vec("bus_dat", bus.O_bus_dat, sb_q[0].dat);
                end
                if (mode != 3 && stb_n > waits) begin
                    bus.I_bus_ack = (mode == 0 || mode == 2);
                    bus.I_bus_err = (mode == 1 || mode == 2);
                    bus.I_bus_dat = bdat;
                end
            end
            if (bus.O_done) begin
                done = 1'b1;
                r = sb_q.pop_front();
                check_vec("misaligned", {31'd0, bus.O_misaligned}, {31'd0, r.mis});
                check_vec("bus_err", {31'd0, bus.O_bus_err}, {31'd0, r.err});
                check_vec("rdata", bus.O_rdata, r.rdata);
                check_vec("done_cycle", 32'(cyc), 32'(r.done_cyc));
                check_vec("cyc_at_done", {31'd0, bus.O_bus_cyc}, 32'd0);
                check_vec("stall_done", {31'd0, bus.O_stall}, 32'd0);
                check_vec("stb_cycles", 32'(stb_n), 32'(r.stb_cnt));
                bus.I_req = 1'b0;
            end
        end
        if (!done) begin
            n_vec++; n_miss++;
            $display("FAIL done_timeout: got no O_done expected within 40 cycles");
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            bus.I_req = 1'b0;
        end
    endtask

    initial begin
        bus.I_req = 1'b0; bus.I_we = 1'b0; bus.I_size = 2'b00;
        bus.I_addr = 32'd0; bus.I_wdata = 32'd0;
        bus.I_bus_dat = 32'd0; bus.I_bus_ack = 1'b0; bus.I_bus_err = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("rst_cyc", {31'd0, bus.O_bus_cyc}, 32'd0);
        check_vec("rst_done", {31'd0, bus.O_done}, 32'd0);
        check_vec("rst_rdata", bus.O_rdata, 32'd0);
        check_vec("rst_stall", {31'd0, bus.O_stall}, 32'd0);
        rst_n = 1'b1;

        run_access(1'b1, SIZE_B, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0);
        run_access(1'b0, SIZE_H, 32'h0000_2002, 32'd0, 2, 0, 32'hBEEF_1234);
        run_access(1'b0, SIZE_W, 32'h0000_3001, 32'd0, 0, 0, 32'hFFFF_FFFF);
        run_access(1'b1, SIZE_H, 32'h0000_5006, 32'h1234_ABCD, 1, 0, 32'd0);
        run_access(1'b1, SIZE_W, 32'h0000_6000, 32'h1234_5678, 0, 0, 32'd0);
        run_access(1'b0, SIZE_B, 32'h0000_7001, 32'd0, 0, 0, 32'h1122_3344);
        run_access(1'b0, SIZE_W, 32'h0000_8000, 32'd0, 0, 3, 32'd0);
        run_access(1'b0, SIZE_W, 32'h0000_8004, 32'd0, 0, 0, 32'hCAFE_F00D);
        run_access(1'b0, SIZE_H, 32'h0000_9000, 32'd0, 0, 2, 32'h5555_AAAA);
        run_access(1'b1, SIZE_B, 32'h0000_9401, 32'h0000_0077, 1, 1, 32'd0);
        run_access(1'b1, SIZE_H, 32'h0000_0001, 32'h0000_BEEF, 0, 0, 32'd0);
        run_access(1'b0, 2'b11, 32'h0000_A000, 32'd0, 0, 0, 32'h0BAD_CAFE);
        run_access(1'b0, SIZE_B, 32'h0000_A003, 32'd0, 3, 0, 32'h9988_7766);

        // Reset in the middle of an access with no bus response.
        @(negedge clk);
        bus.I_req = 1'b1; bus.I_we = 1'b0; bus.I_size = SIZE_W;
        bus.I_addr = 32'h0000_4000; bus.I_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check_vec("mid_access_stb", {31'd0, bus.O_bus_stb}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("rst_mid_cyc", {31'd0, bus.O_bus_cyc}, 32'd0);
        check_vec("rst_mid_stb", {31'd0, bus.O_bus_stb}, 32'd0);
        check_vec("rst_mid_done", {31'd0, bus.O_done}, 32'd0);
        check_vec("rst_mid_rdata", bus.O_rdata, 32'd0);
        check_vec("rst_mid_adr", bus.O_bus_adr, 32'd0);
        model_rdata = 32'd0;
        bus.I_req = 1'b0;
        rst_n = 1'b1;

        run_access(1'b0, SIZE_W, 32'h0000_4000, 32'd0, 0, 0, 32'h0F0F_1234);
        run_access(1'b1, SIZE_W, 32'h0000_4004, 32'hA1B2_C3D4, 0, 0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
